rv32i_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I SOC datapath: instruction register, register bank, ALU and PC.
- Replaces the inline FETCH_INSTR/FETCH_REGS/EXECUTE state machine with a standalone controller.
- Adds a ready-handshaked memory interface, so instruction fetch, load and store can take variable latency.
- Emits one-cycle enables to the datapath, counts retired instructions, and halts on EBREAK, illegal opcodes or a memory timeout.

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/rv32i_ctrl_fsm_if.sv | 10 +
 rtl/rv32i_opclass.sv | 34 +++
 rtl/rv32i_ctrl_fsm.sv | 145 ++++++++++++++
 tb/tb_rv32i_ctrl_fsm.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes and controller state encodings.
package rv32i_pkg;

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH_INSTR = 3'd0,
    ST_WAIT_INSTR  = 3'd1,
    ST_FETCH_REGS  = 3'd2,
    ST_EXECUTE     = 3'd3,
    ST_LOAD        = 3'd4,
    ST_STORE       = 3'd5,
    ST_WAIT_DATA   = 3'd6,
    ST_HALT        = 3'd7
  } state_t;

endpackage

// File: rtl/rv32i_ctrl_fsm_if.sv
// Ready-handshaked memory request bus between the controller and memory.
interface rv32i_ctrl_fsm_if;
  logic mem_rstrb;
  logic mem_wstrb_en;
  logic mem_addr_sel;
  logic mem_rdy;

  modport master (output mem_rstrb, output mem_wstrb_en, output mem_addr_sel, input mem_rdy);
  modport slave  (input mem_rstrb, input mem_wstrb_en, input mem_addr_sel, output mem_rdy);
endinterface

// File: rtl/rv32i_opclass.sv
// Combinational opcode-to-class decode, shared with the datapath.
module rv32i_opclass
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_alu,     // single-cycle class that writes rd (ALU, LUI, AUIPC, jumps)
  output logic       is_load,
  output logic       is_store,
  output logic       is_system,
  output logic       is_branch,
  output logic       writes_rd,
  output logic       legal
);

  // Classify the major opcode
  always_comb begin
    is_alu    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_system = 1'b0;
    is_branch = 1'b0;
    unique case (opcode)
      OP_ALUREG, OP_ALUIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_alu = 1'b1;
      OP_BRANCH: is_branch = 1'b1;
      OP_LOAD:   is_load   = 1'b1;
      OP_STORE:  is_store  = 1'b1;
      OP_SYSTEM: is_system = 1'b1;
      default: ;
    endcase
    writes_rd = is_alu | is_load;
    legal     = is_alu | is_branch | is_load | is_store | is_system;
  end

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer with handshaked memory and wait timeout.
module rv32i_ctrl_fsm
  import rv32i_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [6:0]       opcode,
  rv32i_ctrl_fsm_if.master mem,
  output logic             instr_we,
  output logic             regs_we,
  output logic             wb_en,
  output logic             pc_we,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [TW-1:0] LIMIT = TW'(WAIT_TIMEOUT - 1);

  state_t        st;
  logic [TW-1:0] wait_cnt;
  logic          is_alu, is_load, is_store, is_system, is_branch, writes_rd, legal;
  logic          timeout;

  rv32i_opclass u_opclass (
    .opcode    (opcode),
    .is_alu    (is_alu),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_system (is_system),
    .is_branch (is_branch),
    .writes_rd (writes_rd),
    .legal     (legal)
  );

  assign timeout = (WAIT_TIMEOUT != 0) && (wait_cnt == LIMIT) && !mem.mem_rdy;
  assign state   = st;

  // Sequencer state, wait timer, retired count and sticky fault flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st       <= ST_FETCH_INSTR;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      unique case (st)
        ST_FETCH_INSTR: begin
          st       <= ST_WAIT_INSTR;
          wait_cnt <= '0;
        end
        ST_WAIT_INSTR: begin
          if (mem.mem_rdy) begin
            st <= ST_FETCH_REGS;
          end else if (timeout) begin
            st      <= ST_HALT;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_FETCH_REGS: st <= ST_EXECUTE;
        ST_EXECUTE: begin
          if (is_alu || is_branch) begin
            st      <= ST_FETCH_INSTR;
            instret <= instret + CNT_W'(1);
          end else if (is_load) begin
            st <= ST_LOAD;
          end else if (is_store) begin
            st <= ST_STORE;
          end else if (is_system) begin
            st <= ST_HALT;
          end else begin
            st      <= ST_HALT;
            illegal <= 1'b1;
          end
        end
        ST_LOAD, ST_STORE: begin
          st       <= ST_WAIT_DATA;
          wait_cnt <= '0;
        end
        ST_WAIT_DATA: begin
          if (mem.mem_rdy) begin
            st      <= ST_FETCH_INSTR;
            instret <= instret + CNT_W'(1);
          end else if (timeout) begin
            st      <= ST_HALT;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_HALT: st <= ST_HALT;
        default: st <= ST_HALT;
      endcase
    end
  end

  // Strobe/enable decode from state; gated by resetn so a reset mid-transfer
  // drops every request at once even though FETCH_INSTR itself asserts mem_rstrb
  always_comb begin
    mem.mem_rstrb    = 1'b0;
    mem.mem_wstrb_en = 1'b0;
    mem.mem_addr_sel = 1'b0;
    instr_we         = 1'b0;
    regs_we          = 1'b0;
    wb_en            = 1'b0;
    pc_we            = 1'b0;
    halted           = 1'b0;
    if (resetn) begin
      unique case (st)
        ST_FETCH_INSTR: mem.mem_rstrb = 1'b1;
        ST_WAIT_INSTR:  instr_we = mem.mem_rdy;
        ST_FETCH_REGS:  regs_we = 1'b1;
        ST_EXECUTE: begin
          pc_we = is_alu | is_branch;
          wb_en = is_alu;
        end
        ST_LOAD: begin
          mem.mem_rstrb    = 1'b1;
          mem.mem_addr_sel = 1'b1;
        end
        ST_STORE: begin
          mem.mem_wstrb_en = 1'b1;
          mem.mem_addr_sel = 1'b1;
        end
        ST_WAIT_DATA: begin
          mem.mem_addr_sel = 1'b1;
          pc_we            = mem.mem_rdy;
          wb_en            = mem.mem_rdy & is_load;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Directed self-checking bench for the RV32I control sequencer.
module tb_rv32i_ctrl_fsm;
  import rv32i_pkg::*;

  typedef struct packed {
    logic       rdy;
    logic [6:0] op;
    logic [2:0] st;
    logic [7:0] o;   // {rstrb, wstrb_en, addr_sel, instr_we, regs_we, wb_en, pc_we, halted}
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [6:0]  opcode = '0;
  logic        instr_we, regs_we, wb_en, pc_we, halted, illegal, bus_err;
  logic [2:0]  state;
  logic [31:0] instret;
  int          checks = 0;
  int          errors = 0;

  rv32i_ctrl_fsm_if bus();

  rv32i_ctrl_fsm #(.WAIT_TIMEOUT(8), .CNT_W(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .opcode   (opcode),
    .mem      (bus),
    .instr_we (instr_we),
    .regs_we  (regs_we),
    .wb_en    (wb_en),
    .pc_we    (pc_we),
    .halted   (halted),
    .illegal  (illegal),
    .bus_err  (bus_err),
    .state    (state),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus.mem_rstrb, bus.mem_wstrb_en, bus.mem_addr_sel, instr_we, regs_we, wb_en, pc_we, halted};
  endfunction

  task automatic apply_reset();
    resetn = 1'b0;
    bus.mem_rdy = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.mem_rdy = 1'b0;
    #1;
    checks++;
    if ({state, outs()} !== {3'd0, 8'h00}) begin
      errors++; $display("FAIL reset_outs: got st=%0d out=%b want st=0 out=00000000", state, outs());
    end
    checks++;
    if ({instret, illegal, bus_err} !== {32'd0, 2'b00}) begin
      errors++; $display("FAIL reset_cnt: got instret=%0d ill=%b berr=%b want 0 0 0", instret, illegal, bus_err);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_addi_back_to_back();
    vec_t v [8];
    v = '{'{1'b0, OP_ALUIMM, 3'd0, 8'h80}, '{1'b1, OP_ALUIMM, 3'd1, 8'h10},
          '{1'b0, OP_ALUIMM, 3'd2, 8'h08}, '{1'b0, OP_ALUIMM, 3'd3, 8'h06},
          '{1'b0, OP_ALUIMM, 3'd0, 8'h80}, '{1'b1, OP_ALUIMM, 3'd1, 8'h10},
          '{1'b0, OP_ALUIMM, 3'd2, 8'h08}, '{1'b0, OP_ALUIMM, 3'd3, 8'h06}};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      bus.mem_rdy = v[i].rdy; opcode = v[i].op; #1;
      checks++;
      if ({state, outs()} !== {v[i].st, v[i].o}) begin
        errors++; $display("FAIL addi c%0d: got st=%0d out=%b want st=%0d out=%b", i, state, outs(), v[i].st, v[i].o);
      end
      if (i == 4) begin
        checks++;
        if (instret !== 32'd1) begin
          errors++; $display("FAIL addi_instret: got %0d want 1", instret);
        end
      end
      @(posedge clk); #1;
    end
    bus.mem_rdy = 1'b0; #1;
    checks++;
    if ({state, instret} !== {3'd0, 32'd2}) begin
      errors++; $display("FAIL b2b_end: got st=%0d instret=%0d want st=0 instret=2", state, instret);
    end
  endtask

  task automatic test_load();
    vec_t v [10];
    v = '{'{1'b0, OP_LOAD, 3'd0, 8'h80}, '{1'b1, OP_LOAD, 3'd1, 8'h10},
          '{1'b0, OP_LOAD, 3'd2, 8'h08}, '{1'b0, OP_LOAD, 3'd3, 8'h00},
          '{1'b0, OP_LOAD, 3'd4, 8'hA0}, '{1'b0, OP_LOAD, 3'd6, 8'h20},
          '{1'b0, OP_LOAD, 3'd6, 8'h20}, '{1'b0, OP_LOAD, 3'd6, 8'h20},
          '{1'b1, OP_LOAD, 3'd6, 8'h26}, '{1'b0, OP_LOAD, 3'd0, 8'h80}};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      bus.mem_rdy = v[i].rdy; opcode = v[i].op; #1;
      checks++;
      if ({state, outs()} !== {v[i].st, v[i].o}) begin
        errors++; $display("FAIL load c%0d: got st=%0d out=%b want st=%0d out=%b", i, state, outs(), v[i].st, v[i].o);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret !== 32'd1) begin
      errors++; $display("FAIL load_instret: got %0d want 1", instret);
    end
  endtask

  task automatic test_store();
    vec_t v [7];
    v = '{'{1'b0, OP_STORE, 3'd0, 8'h80}, '{1'b1, OP_STORE, 3'd1, 8'h10},
          '{1'b0, OP_STORE, 3'd2, 8'h08}, '{1'b0, OP_STORE, 3'd3, 8'h00},
          '{1'b0, OP_STORE, 3'd5, 8'h60}, '{1'b1, OP_STORE, 3'd6, 8'h22},
          '{1'b0, OP_STORE, 3'd0, 8'h80}};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      bus.mem_rdy = v[i].rdy; opcode = v[i].op; #1;
      checks++;
      if ({state, outs()} !== {v[i].st, v[i].o}) begin
        errors++; $display("FAIL store c%0d: got st=%0d out=%b want st=%0d out=%b", i, state, outs(), v[i].st, v[i].o);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret !== 32'd1) begin
      errors++; $display("FAIL store_instret: got %0d want 1", instret);
    end
  endtask

  task automatic test_branch_ebreak();
    vec_t v [11];
    v = '{'{1'b0, OP_BRANCH, 3'd0, 8'h80}, '{1'b1, OP_BRANCH, 3'd1, 8'h10},
          '{1'b0, OP_BRANCH, 3'd2, 8'h08}, '{1'b0, OP_BRANCH, 3'd3, 8'h02},
          '{1'b0, OP_SYSTEM, 3'd0, 8'h80}, '{1'b1, OP_SYSTEM, 3'd1, 8'h10},
          '{1'b0, OP_SYSTEM, 3'd2, 8'h08}, '{1'b0, OP_SYSTEM, 3'd3, 8'h00},
          '{1'b0, OP_SYSTEM, 3'd7, 8'h01}, '{1'b1, OP_SYSTEM, 3'd7, 8'h01},
          '{1'b1, OP_SYSTEM, 3'd7, 8'h01}};
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      bus.mem_rdy = v[i].rdy; opcode = v[i].op; #1;
      checks++;
      if ({state, outs()} !== {v[i].st, v[i].o}) begin
        errors++; $display("FAIL brk c%0d: got st=%0d out=%b want st=%0d out=%b", i, state, outs(), v[i].st, v[i].o);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({instret, illegal, bus_err} !== {32'd1, 2'b00}) begin
      errors++; $display("FAIL brk_end: got instret=%0d ill=%b berr=%b want 1 0 0", instret, illegal, bus_err);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    opcode = OP_ALUIMM;
    // no ready at all: WAIT_INSTR from cycle 1, HALT at cycle 9
    for (int i = 0; i < 10; i++) begin
      bus.mem_rdy = 1'b0; #1;
      checks++;
      if (state !== ((i == 0) ? 3'd0 : (i == 9) ? 3'd7 : 3'd1)) begin
        errors++; $display("FAIL tmo c%0d: got st=%0d want %0d", i, state, (i == 0) ? 0 : (i == 9) ? 7 : 1);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({halted, bus_err, illegal} !== 3'b110) begin
      errors++; $display("FAIL tmo_flags: got h=%b berr=%b ill=%b want 1 1 0", halted, bus_err, illegal);
    end
    // ready on the limit cycle completes the fetch
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      bus.mem_rdy = (i == 8); #1;
      checks++;
      if (state !== ((i == 0 || i == 11) ? 3'd0 : (i == 9) ? 3'd2 : (i == 10) ? 3'd3 : 3'd1)) begin
        errors++; $display("FAIL tmo_edge c%0d: got st=%0d", i, state);
      end
      if (i == 8) begin
        checks++;
        if (instr_we !== 1'b1) begin
          errors++; $display("FAIL tmo_edge_iwe: got %b want 1", instr_we);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({bus_err, instret} !== {1'b0, 32'd1}) begin
      errors++; $display("FAIL tmo_edge_end: got berr=%b instret=%0d want 0 1", bus_err, instret);
    end
  endtask

  task automatic test_illegal_and_midreset();
    apply_reset();
    opcode = 7'b0000000;
    for (int i = 0; i < 5; i++) begin
      bus.mem_rdy = (i == 1);
      @(posedge clk); #1;
    end
    checks++;
    if ({state, halted, illegal, bus_err} !== {3'd7, 3'b110}) begin
      errors++; $display("FAIL illegal: got st=%0d h=%b ill=%b berr=%b want 7 1 1 0", state, halted, illegal, bus_err);
    end
    // one ADDI, then a load left hanging in WAIT_DATA
    apply_reset();
    opcode = OP_ALUIMM;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rdy = (i == 1);
      @(posedge clk); #1;
    end
    opcode = OP_LOAD;
    for (int i = 0; i < 6; i++) begin
      bus.mem_rdy = (i == 1);
      @(posedge clk); #1;
    end
    bus.mem_rdy = 1'b0; #1;
    checks++;
    if ({state, outs(), instret} !== {3'd6, 8'h20, 32'd1}) begin
      errors++; $display("FAIL midrst_pre: got st=%0d out=%b instret=%0d want 6 00100000 1", state, outs(), instret);
    end
    resetn = 1'b0; #1;
    checks++;
    if ({state, outs(), instret} !== {3'd0, 8'h00, 32'd0}) begin
      errors++; $display("FAIL midrst: got st=%0d out=%b instret=%0d want 0 00000000 0", state, outs(), instret);
    end
    @(posedge clk); #1;
    resetn = 1'b1; #1;
    checks++;
    if ({state, outs(), illegal} !== {3'd0, 8'h80, 1'b0}) begin
      errors++; $display("FAIL midrst_post: got st=%0d out=%b ill=%b want 0 10000000 0", state, outs(), illegal);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.mem_rdy = 1'b0;
    test_reset();
    test_addi_back_to_back();
    test_load();
    test_store();
    test_branch_ebreak();
    test_timeout();
    test_illegal_and_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
